date_set_ctrl: RTL and testbench
================================

# date_set_ctrl

Button-driven date-setting controller that sequences writes into the calendar datapath (`datemodule`). It captures the running date, lets the user edit day, month and year one field at a time with two debounced buttons, enforces calendar validity, and then drives `date_in`/`date_ow` into `datemodule` for a fixed overwrite window. It sits between the front-panel button conditioner and `datemodule`.

## Interface
- `OW_CYCLES`, default 2: cycles `date_ow` is held high on commit (≥1).
- `TIMEOUT`, default 50_000_000: idle cycles in an edit state before the edit is abandoned without commit (≥2).
- `clk` in 1: system clock, rising edge.
- `rst_n` in 1: reset, asynchronous active-low.
- `mode_btn` in 1: single-cycle debounced pulse; enters edit mode, advances field, commits.
- `inc_btn` in 1: single-cycle debounced pulse; increments the selected field.
- `date_cur` in 19: current date from `datemodule.date_out`.
- `date_in` out 19: date word to `datemodule.date_in`.
- `date_ow` out 1: overwrite strobe to `datemodule.date_ow`.
- `editing` out 1: high in SET_DAY, SET_MONTH, SET_YEAR.
- `field` out 2: 0 = none, 1 = day, 2 = month, 3 = year (display blink select).

Date word, BCD, MSB first: day tens[18:17], day ones[16:13], month tens[12], month ones[11:8], year tens[7:4], year ones[3:0]. Year 00–99 means 2000–2099.

## Operation
- States: IDLE, SET_DAY, SET_MONTH, SET_YEAR, COMMIT.
- IDLE + `mode_btn`: load the edit register from `date_cur`, then go to SET_DAY.
- SET_DAY + `mode_btn`: go to SET_MONTH.
- SET_MONTH + `mode_btn`: go to SET_YEAR.
- SET_YEAR + `mode_btn`: go to COMMIT.
- COMMIT: after OW_CYCLES cycles, go to IDLE. Buttons are ignored in COMMIT.
- `inc_btn` in an edit state increments the selected field:
  - Day runs 01 up to the maximum for the month, then wraps to 01.
  - Month runs 01..12, then wraps to 01.
  - Year runs 00..99, then wraps to 00.
  - Increments stay in BCD: ones digit 9 rolls over to 0 and carries into tens.
- Month maximum: 31 for 01, 03, 05, 07, 08, 10, 12; 30 for 04, 06, 09, 11; 29 for 02 in a leap year, else 28.
- Leap year: tens even and ones ∈ {0, 4, 8}, or tens odd and ones ∈ {2, 6}.
- Day clamp: any month or year change that leaves day above the new maximum sets day to that maximum in the same update.
- Invalid `date_cur` on capture: day 00 becomes 01, month 00 or >12 becomes 01, then the clamp is applied.
- Timeout: in an edit state, a counter resets on any button pulse and counts otherwise. When it reaches TIMEOUT−1, go to IDLE with no commit.
- Simultaneous `mode_btn` and `inc_btn`: `mode_btn` wins and `inc_btn` is dropped.
- Reset asserted mid-edit or mid-commit: return to IDLE immediately and drop the edit; no partial overwrite is issued.

## Timing
- Reset values: state IDLE, `date_in` = 0, `date_ow` = 0, `editing` = 0, `field` = 0, timeout counter = 0.
- All outputs are registered. A button pulse in cycle N is reflected in the outputs at the edge ending cycle N.
- `date_in` tracks the edit register during editing. It is stable for every cycle `date_ow` is high and holds its value in IDLE afterwards.
- `date_ow` is high for exactly OW_CYCLES consecutive cycles, starting the cycle after the committing `mode_btn`.
- `date_cur` is sampled only on the IDLE→SET_DAY transition.

## Structure
- Shared package `clock_pkg`:
  - state enum;
  - date field bit-position constants;
  - `FIELD_*` codes;
  - a `days_in_month(month_bcd, year_bcd)` function, which `datemodule` can reuse.
- One sub-module, `bcd_field_inc`: combinational BCD increment with configurable min/max and wrap. It is instantiated once per field.
- The FSM, timeout counter and output registers live in the top.

## Test plan
- Capture then commit unchanged: `date_cur` = 15-08-23, press mode ×4 → `date_ow` high for 2 cycles with `date_in` = 15-08-23, then IDLE.
- Day wrap: capture 30-04-23, inc on day once → 01-04-23.
- Leap clamp: capture 31-01-24, go to month, inc → month 02, day clamped to 29. Then go to year, inc → year 25, day clamped to 28. Commit → `date_in` = 28-02-25.
- BCD carry: year 09 inc → 10; year 99 inc → 00; month 09 inc → 10; month 12 inc → 01.
- Timeout and precedence: with TIMEOUT = 8, enter SET_DAY and send no presses → IDLE after 8 cycles with `date_ow` never high. In a separate run, mode and inc asserted together in SET_DAY → SET_MONTH with day unchanged.
- Reset mid-commit: assert `rst_n` = 0 during the first `date_ow` cycle → `date_ow` drops asynchronously, all outputs return to reset values, state is IDLE.

Source files
------------

// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared calendar types, field layout and month-length helpers
package clock_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SET_DAY,
    ST_SET_MONTH,
    ST_SET_YEAR,
    ST_COMMIT
  } state_t;

  localparam int DAY_MSB  = 18;
  localparam int DAY_LSB  = 13;
  localparam int MON_MSB  = 12;
  localparam int MON_LSB  = 8;
  localparam int YEAR_MSB = 7;
  localparam int YEAR_LSB = 0;

  localparam logic [1:0] FIELD_NONE  = 2'd0;
  localparam logic [1:0] FIELD_DAY   = 2'd1;
  localparam logic [1:0] FIELD_MONTH = 2'd2;
  localparam logic [1:0] FIELD_YEAR  = 2'd3;

  // Years are 2000-2099, so divisibility by 4 decides leap years; in BCD that
  // depends only on the parity of the tens digit and the ones digit.
  function automatic logic [5:0] days_in_month(input logic [4:0] month_bcd,
                                               input logic [7:0] year_bcd);
    logic leap;
    leap = year_bcd[4] ? (year_bcd[3:0] == 4'd2 || year_bcd[3:0] == 4'd6)
                       : (year_bcd[3:0] == 4'd0 || year_bcd[3:0] == 4'd4 ||
                          year_bcd[3:0] == 4'd8);
    case (month_bcd)
      5'h04, 5'h06, 5'h09, 5'h11: days_in_month = 6'h30;
      5'h02:                      days_in_month = leap ? 6'h29 : 6'h28;
      default:                    days_in_month = 6'h31;
    endcase
  endfunction

  function automatic logic [5:0] clamp_day(input logic [5:0] day_bcd,
                                           input logic [5:0] max_bcd);
    clamp_day = (day_bcd > max_bcd) ? max_bcd : day_bcd;
  endfunction

endpackage

// File: rtl/bcd_field_inc.sv
// rtl/bcd_field_inc.sv - combinational two-digit BCD increment with min/max wrap
module bcd_field_inc #(
  parameter int TENS_W = 4
) (
  input  logic [TENS_W+3:0] value,
  input  logic [TENS_W+3:0] min_value,
  input  logic [TENS_W+3:0] max_value,
  output logic [TENS_W+3:0] next_value
);

  // BCD ordering matches binary ordering, so a plain compare finds the wrap point.
  always_comb begin
    next_value = min_value;
    if (value < max_value) begin
      if (value[3:0] >= 4'd9) begin
        next_value = {value[TENS_W+3:4] + TENS_W'(1), 4'd0};
      end else begin
        next_value = {value[TENS_W+3:4], value[3:0] + 4'd1};
      end
    end
  end

endmodule

// File: rtl/date_set_ctrl.sv
// rtl/date_set_ctrl.sv - button-driven date edit FSM feeding the calendar overwrite port
module date_set_ctrl
  import clock_pkg::*;
#(
  parameter int OW_CYCLES = 2,
  parameter int TIMEOUT   = 50_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mode_btn,
  input  logic        inc_btn,
  input  logic [18:0] date_cur,
  output logic [18:0] date_in,
  output logic        date_ow,
  output logic        editing,
  output logic [1:0]  field
);

  localparam int TCNT_W = $clog2(TIMEOUT);
  localparam int OCNT_W = (OW_CYCLES > 1) ? $clog2(OW_CYCLES) : 1;

  state_t state, next_state;
  logic [TCNT_W-1:0] tcnt;
  logic [OCNT_W-1:0] ocnt;
  logic [5:0] day;
  logic [4:0] mon;
  logic [7:0] year;

  logic       in_edit, timeout_hit, ow_done;
  logic [5:0] cur_day, cap_day;
  logic [4:0] cur_mon, cap_mon;
  logic [7:0] cur_year;
  logic [5:0] day_max, day_next;
  logic [4:0] mon_next;
  logic [7:0] year_next;
  logic       editing_d, date_ow_d;
  logic [1:0] field_d;

  assign date_in = {day, mon, year};

  assign in_edit     = (state == ST_SET_DAY) || (state == ST_SET_MONTH) || (state == ST_SET_YEAR);
  assign timeout_hit = in_edit && !mode_btn && !inc_btn && (tcnt == TCNT_W'(TIMEOUT - 1));
  assign ow_done     = (ocnt == OCNT_W'(OW_CYCLES - 1));

  // Captured date is repaired so the edit always starts from a valid calendar date.
  assign cur_day  = date_cur[DAY_MSB:DAY_LSB];
  assign cur_mon  = date_cur[MON_MSB:MON_LSB];
  assign cur_year = date_cur[YEAR_MSB:YEAR_LSB];
  assign cap_mon  = (cur_mon == 5'h00 || cur_mon > 5'h12) ? 5'h01 : cur_mon;
  assign cap_day  = clamp_day((cur_day == 6'h00) ? 6'h01 : cur_day,
                              days_in_month(cap_mon, cur_year));

  assign day_max = days_in_month(mon, year);

  bcd_field_inc #(.TENS_W(2)) u_day_inc (
    .value(day), .min_value(6'h01), .max_value(day_max), .next_value(day_next)
  );
  bcd_field_inc #(.TENS_W(1)) u_mon_inc (
    .value(mon), .min_value(5'h01), .max_value(5'h12), .next_value(mon_next)
  );
  bcd_field_inc #(.TENS_W(4)) u_year_inc (
    .value(year), .min_value(8'h00), .max_value(8'h99), .next_value(year_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:      if (mode_btn) next_state = ST_SET_DAY;
      ST_SET_DAY:   if (mode_btn) next_state = ST_SET_MONTH;
                    else if (timeout_hit) next_state = ST_IDLE;
      ST_SET_MONTH: if (mode_btn) next_state = ST_SET_YEAR;
                    else if (timeout_hit) next_state = ST_IDLE;
      ST_SET_YEAR:  if (mode_btn) next_state = ST_COMMIT;
                    else if (timeout_hit) next_state = ST_IDLE;
      ST_COMMIT:    if (ow_done) next_state = ST_IDLE;
      default:      next_state = ST_IDLE;
    endcase
  end

  // Outputs are decoded from next_state and registered so they change on the same edge as state.
  always_comb begin
    editing_d = 1'b0;
    date_ow_d = 1'b0;
    field_d   = FIELD_NONE;
    case (next_state)
      ST_SET_DAY:   begin editing_d = 1'b1; field_d = FIELD_DAY;   end
      ST_SET_MONTH: begin editing_d = 1'b1; field_d = FIELD_MONTH; end
      ST_SET_YEAR:  begin editing_d = 1'b1; field_d = FIELD_YEAR;  end
      ST_COMMIT:    date_ow_d = 1'b1;
      default:      ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      editing <= 1'b0;
      date_ow <= 1'b0;
      field   <= FIELD_NONE;
    end else begin
      editing <= editing_d;
      date_ow <= date_ow_d;
      field   <= field_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt <= '0;
      ocnt <= '0;
    end else begin
      if (in_edit && next_state == state && !mode_btn && !inc_btn) tcnt <= tcnt + TCNT_W'(1);
      else                                                         tcnt <= '0;
      if (state == ST_COMMIT && next_state == ST_COMMIT) ocnt <= ocnt + OCNT_W'(1);
      else                                               ocnt <= '0;
    end
  end

  // Month and year changes re-clamp the day in the same update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      day  <= '0;
      mon  <= '0;
      year <= '0;
    end else if (state == ST_IDLE && mode_btn) begin
      day  <= cap_day;
      mon  <= cap_mon;
      year <= cur_year;
    end else if (in_edit && inc_btn && !mode_btn) begin
      case (state)
        ST_SET_DAY: day <= day_next;
        ST_SET_MONTH: begin
          mon <= mon_next;
          day <= clamp_day(day, days_in_month(mon_next, year));
        end
        ST_SET_YEAR: begin
          year <= year_next;
          day  <= clamp_day(day, days_in_month(mon, year_next));
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_date_set_ctrl.sv
// tb/tb_date_set_ctrl.sv - scoreboard bench for date_set_ctrl
module tb_date_set_ctrl;

  localparam int OW = 2;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mode_btn = 1'b0;
  logic        inc_btn = 1'b0;
  logic [18:0] date_cur = '0;
  logic [18:0] date_in;
  logic        date_ow;
  logic        editing;
  logic [1:0]  field;

  date_set_ctrl #(.OW_CYCLES(OW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .mode_btn(mode_btn), .inc_btn(inc_btn),
    .date_cur(date_cur), .date_in(date_in), .date_ow(date_ow),
    .editing(editing), .field(field)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [18:0] sb[$];
  int md, mm, my;

  logic        in_burst = 1'b0;
  logic        have_exp = 1'b0;
  int          burst_len = 0;
  logic [18:0] exp_word = '0;

  function automatic logic [18:0] to_word(input int d, input int m, input int y);
    logic [18:0] w;
    w[18:17] = 2'(d / 10);
    w[16:13] = 4'(d % 10);
    w[12]    = 1'(m / 10);
    w[11:8]  = 4'(m % 10);
    w[7:4]   = 4'(y / 10);
    w[3:0]   = 4'(y % 10);
    return w;
  endfunction

  function automatic int dim(input int m, input int y);
    case (m)
      4, 6, 9, 11: return 30;
      2:           return (y % 4 == 0) ? 29 : 28;
      default:     return 31;
    endcase
  endfunction

  task automatic model_capture(input logic [18:0] w);
    md = int'(w[18:17]) * 10 + int'(w[16:13]);
    mm = int'(w[12]) * 10 + int'(w[11:8]);
    my = int'(w[7:4]) * 10 + int'(w[3:0]);
    if (md == 0) md = 1;
    if (mm == 0 || mm > 12) mm = 1;
    if (md > dim(mm, my)) md = dim(mm, my);
  endtask

  task automatic model_inc(input int f);
    case (f)
      1: md = (md >= dim(mm, my)) ? 1 : md + 1;
      2: mm = (mm == 12) ? 1 : mm + 1;
      default: my = (my == 99) ? 0 : my + 1;
    endcase
    if (md > dim(mm, my)) md = dim(mm, my);
  endtask

  task automatic press(input logic m, input logic i);
    @(posedge clk); #1;
    mode_btn = m;
    inc_btn  = i;
    @(posedge clk); #1;
    mode_btn = 1'b0;
    inc_btn  = 1'b0;
  endtask

  // Overwrite monitor: each burst pops one expected word and must last exactly OW cycles.
  always @(negedge clk) begin
    if (!rst_n) begin
      in_burst  = 1'b0;
      burst_len = 0;
    end else if (date_ow) begin
      if (!in_burst) begin
        in_burst  = 1'b1;
        burst_len = 0;
        if (sb.size() == 0) begin
          checks++; errors++;
          have_exp = 1'b0;
          $display("FAIL ow_unexpected: date_ow high with date_in=%h, no commit expected", date_in);
        end else begin
          exp_word = sb.pop_front();
          have_exp = 1'b1;
        end
      end
      burst_len++;
      if (have_exp) begin
        checks++;
        if (date_in !== exp_word) begin
          errors++;
          $display("FAIL ow_date_in: got %h expected %h", date_in, exp_word);
        end
      end
    end else if (in_burst) begin
      in_burst = 1'b0;
      checks++;
      if (burst_len != OW) begin
        errors++;
        $display("FAIL ow_length: got %0d cycles expected %0d", burst_len, OW);
      end
    end
  end

  task automatic wait_commit_done();
    int n = 0;
    while ((sb.size() != 0 || date_ow) && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n >= 30 || editing !== 1'b0 || field !== 2'd0) begin
      errors++;
      $display("FAIL commit_done: waited %0d editing=%b field=%0d pending=%0d", n, editing, field, sb.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (date_in !== 19'd0 || date_ow !== 1'b0 || editing !== 1'b0 || field !== 2'd0) begin
      errors++;
      $display("FAIL reset_outputs: date_in=%h ow=%b editing=%b field=%0d want all 0",
               date_in, date_ow, editing, field);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_commit_unchanged();
    date_cur = to_word(15, 8, 23);
    model_capture(date_cur);
    for (int k = 1; k <= 3; k++) begin
      press(1'b1, 1'b0);
      checks++;
      if (editing !== 1'b1 || field !== 2'(k) || date_in !== to_word(15, 8, 23)) begin
        errors++;
        $display("FAIL unchanged_step%0d: editing=%b field=%0d date_in=%h want 1/%0d/%h",
                 k, editing, field, date_in, k, to_word(15, 8, 23));
      end
    end
    sb.push_back(to_word(15, 8, 23));
    press(1'b1, 1'b0);
    checks++;
    if (date_ow !== 1'b1 || editing !== 1'b0) begin
      errors++;
      $display("FAIL unchanged_ow_start: date_ow=%b editing=%b want 1/0", date_ow, editing);
    end
    wait_commit_done();
    checks++;
    if (date_in !== to_word(15, 8, 23)) begin
      errors++;
      $display("FAIL unchanged_hold: date_in=%h want %h", date_in, to_word(15, 8, 23));
    end
  endtask

  task automatic test_day_wrap();
    date_cur = to_word(30, 4, 23);
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    checks++;
    if (date_in !== to_word(1, 4, 23)) begin
      errors++;
      $display("FAIL day_wrap: date_in=%h want %h", date_in, to_word(1, 4, 23));
    end
    sb.push_back(to_word(1, 4, 23));
    repeat (3) press(1'b1, 1'b0);
    wait_commit_done();
  endtask

  task automatic test_leap_clamp();
    date_cur = to_word(31, 1, 24);
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    checks++;
    if (date_in !== to_word(29, 2, 24)) begin
      errors++;
      $display("FAIL leap_month_clamp: date_in=%h want %h", date_in, to_word(29, 2, 24));
    end
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    checks++;
    if (date_in !== to_word(28, 2, 25)) begin
      errors++;
      $display("FAIL leap_year_clamp: date_in=%h want %h", date_in, to_word(28, 2, 25));
    end
    sb.push_back(to_word(28, 2, 25));
    press(1'b1, 1'b0);
    wait_commit_done();
  endtask

  task automatic test_bcd_carry();
    logic [18:0] starts[2];
    starts[0] = to_word(5, 9, 9);
    starts[1] = to_word(5, 12, 99);
    for (int s = 0; s < 2; s++) begin
      date_cur = starts[s];
      model_capture(date_cur);
      press(1'b1, 1'b0);
      press(1'b1, 1'b0);
      press(1'b0, 1'b1);
      model_inc(2);
      press(1'b1, 1'b0);
      press(1'b0, 1'b1);
      model_inc(3);
      checks++;
      if (date_in !== to_word(md, mm, my)) begin
        errors++;
        $display("FAIL bcd_carry%0d: date_in=%h want %h", s, date_in, to_word(md, mm, my));
      end
      sb.push_back(to_word(md, mm, my));
      press(1'b1, 1'b0);
      wait_commit_done();
    end
  endtask

  task automatic test_timeout();
    int n = 0;
    date_cur = to_word(10, 10, 10);
    press(1'b1, 1'b0);
    while (editing && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n != TO || field !== 2'd0) begin
      errors++;
      $display("FAIL timeout_cycles: left edit after %0d cycles field=%0d want %0d/0", n, field, TO);
    end
  endtask

  task automatic test_precedence();
    int n = 0;
    date_cur = to_word(12, 3, 21);
    press(1'b1, 1'b0);
    press(1'b1, 1'b1);
    checks++;
    if (field !== 2'd2 || date_in !== to_word(12, 3, 21)) begin
      errors++;
      $display("FAIL mode_wins: field=%0d date_in=%h want 2/%h", field, date_in, to_word(12, 3, 21));
    end
    while (editing && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic test_back_to_back();
    for (int it = 0; it < 6; it++) begin
      int d = $urandom_range(0, 31);
      int m = $urandom_range(0, 14);
      int y = $urandom_range(0, 99);
      date_cur = to_word(d, m, y);
      model_capture(date_cur);
      press(1'b1, 1'b0);
      checks++;
      if (date_in !== to_word(md, mm, my)) begin
        errors++;
        $display("FAIL b2b_capture%0d: date_in=%h want %h (cur %h)", it, date_in, to_word(md, mm, my), date_cur);
      end
      for (int f = 1; f <= 3; f++) begin
        int presses = $urandom_range(0, 3);
        for (int p = 0; p < presses; p++) begin
          press(1'b0, 1'b1);
          model_inc(f);
          checks++;
          if (date_in !== to_word(md, mm, my)) begin
            errors++;
            $display("FAIL b2b_inc%0d_f%0d: date_in=%h want %h", it, f, date_in, to_word(md, mm, my));
          end
        end
        if (f == 3) sb.push_back(to_word(md, mm, my));
        press(1'b1, 1'b0);
      end
      wait_commit_done();
    end
  endtask

  task automatic test_reset_mid_commit();
    date_cur = to_word(20, 6, 30);
    repeat (4) press(1'b1, 1'b0);
    checks++;
    if (date_ow !== 1'b1) begin
      errors++;
      $display("FAIL rst_commit_ow: date_ow=%b want 1", date_ow);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (date_in !== 19'd0 || date_ow !== 1'b0 || editing !== 1'b0 || field !== 2'd0) begin
      errors++;
      $display("FAIL rst_commit_outputs: date_in=%h ow=%b editing=%b field=%0d want all 0",
               date_in, date_ow, editing, field);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    press(1'b0, 1'b1);
    checks++;
    if (editing !== 1'b0 || date_in !== 19'd0) begin
      errors++;
      $display("FAIL rst_idle_inc: editing=%b date_in=%h want 0/0", editing, date_in);
    end
    date_cur = to_word(2, 2, 2);
    press(1'b1, 1'b0);
    checks++;
    if (field !== 2'd1 || date_in !== to_word(2, 2, 2)) begin
      errors++;
      $display("FAIL rst_recapture: field=%0d date_in=%h want 1/%h", field, date_in, to_word(2, 2, 2));
    end
    repeat (12) @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_commit_unchanged();
    test_day_wrap();
    test_leap_clamp();
    test_bcd_carry();
    test_timeout();
    test_precedence();
    test_back_to_back();
    test_reset_mid_commit();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expected commits never seen", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
